// File: rtl/isp_raw_stream_gen.sv
// Raw sensor stand-in: frame timing, Bayer test patterns and optional hot/dead pixel injection
// on a pclk/href/vsync/raw interface, with a defect flag aligned to each pixel.
module isp_raw_stream_gen #(
    parameter int BITS        = 8,
    parameter int WIDTH       = 1280,
    parameter int HEIGHT      = 960,
    parameter int HBLANK      = 160,
    parameter int VSYNC_LINES = 2,
    parameter int VBP_LINES   = 2,
    parameter int VFP_LINES   = 2,
    parameter int BAYER       = 0
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [1:0]      mode,
    input  logic [BITS-1:0] level,
    input  logic            defect_en,
    input  logic [7:0]      defect_step,
    output logic            out_href,
    output logic            out_vsync,
    output logic [BITS-1:0] out_raw,
    output logic            out_defect,
    output logic            frame_done
);

    localparam int LINE_LEN    = WIDTH + HBLANK;
    localparam int FRAME_LINES = VSYNC_LINES + VBP_LINES + HEIGHT + VFP_LINES;
    localparam int HW          = $clog2(LINE_LEN + 1);
    localparam int VW          = $clog2(FRAME_LINES + 1);

    localparam logic [HW-1:0] H_LAST      = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] H_ACT       = HW'(WIDTH);
    localparam logic [HW-1:0] H_ACT_LAST  = HW'(WIDTH - 1);
    localparam logic [VW-1:0] V_LAST      = VW'(FRAME_LINES - 1);
    localparam logic [VW-1:0] V_SYNC      = VW'(VSYNC_LINES);
    localparam logic [VW-1:0] V_ACT_START = VW'(VSYNC_LINES + VBP_LINES);
    localparam logic [VW-1:0] V_ACT_LINES = VW'(HEIGHT);
    localparam logic [1:0]    R_POS       = 2'(BAYER);
    localparam logic [15:0]   LFSR_SEED   = 16'hACE1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FRAME = 1'b1;

    logic [0:0]      state;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;

    logic [1:0]      cfg_mode;
    logic [BITS-1:0] cfg_level;
    logic            cfg_defect_en;
    logic [7:0]      cfg_step;
    logic [15:0]     lfsr;
    logic [7:0]      dx;
    logic [7:0]      dy;
    logic            hot;

    logic            running;
    logic            frame_start;
    logic            line_end;
    logic            frame_end;
    logic [VW-1:0]   y_cnt;
    logic            active;
    logic            act_line_end;

    logic [1:0]      eff_mode;
    logic [BITS-1:0] eff_level;
    logic            eff_defect_en;
    logic [7:0]      eff_step;
    logic [15:0]     lfsr_cur;
    logic [15:0]     lfsr_next;
    logic [7:0]      dx_cur;
    logic [7:0]      dy_cur;
    logic [7:0]      dx_wrap;
    logic [7:0]      dy_wrap;
    logic            hot_cur;
    logic [7:0]      step_m1;
    logic            inject;
    logic [BITS-1:0] pat;
    logic [BITS-1:0] raw_next;

    assign running      = (state == ST_FRAME);
    assign frame_start  = running && (h_cnt == '0) && (v_cnt == '0);
    assign line_end     = (h_cnt == H_LAST);
    assign frame_end    = running && line_end && (v_cnt == V_LAST);
    // Unsigned wrap makes rows above the active window compare as out of range.
    assign y_cnt        = v_cnt - V_ACT_START;
    assign active       = running && (y_cnt < V_ACT_LINES) && (h_cnt < H_ACT);
    assign act_line_end = active && (h_cnt == H_ACT_LAST);

    // On the frame-start cycle the snapshot registers are still loading, so use their next values.
    assign eff_mode      = frame_start ? mode        : cfg_mode;
    assign eff_level     = frame_start ? level       : cfg_level;
    assign eff_defect_en = frame_start ? defect_en   : cfg_defect_en;
    assign eff_step      = frame_start ? defect_step : cfg_step;
    assign lfsr_cur      = frame_start ? LFSR_SEED   : lfsr;
    assign dx_cur        = frame_start ? 8'd0        : dx;
    assign dy_cur        = frame_start ? 8'd0        : dy;
    assign hot_cur       = frame_start ? 1'b1        : hot;

    assign lfsr_next = {lfsr_cur[14:0], lfsr_cur[15] ^ lfsr_cur[13] ^ lfsr_cur[12] ^ lfsr_cur[10]};
    assign step_m1   = eff_step - 8'd1;
    assign dx_wrap   = (dx_cur >= step_m1) ? 8'd0 : dx_cur + 8'd1;
    assign dy_wrap   = (dy_cur >= step_m1) ? 8'd0 : dy_cur + 8'd1;
    assign inject    = active && eff_defect_en && (eff_step >= 8'd4) &&
                       (dx_cur == step_m1) && (dy_cur == step_m1);

    always_comb begin
        pat = '0;
        case (eff_mode)
            2'd0: pat = eff_level;
            2'd1: pat = BITS'(h_cnt);
            2'd2: begin
                case ({y_cnt[0] ^ R_POS[1], h_cnt[0] ^ R_POS[0]})
                    2'b00:   pat = eff_level;
                    2'b11:   pat = eff_level >> 2;
                    default: pat = eff_level >> 1;
                endcase
            end
            default: pat = lfsr_cur[15 -: BITS];
        endcase
    end

    assign raw_next = inject ? {BITS{hot_cur}} : pat;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (state == ST_IDLE) begin
            h_cnt <= '0;
            v_cnt <= '0;
            if (enable) begin
                state <= ST_FRAME;
            end
        end else if (line_end) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt <= '0;
                if (!enable) begin
                    state <= ST_IDLE;
                end
            end else begin
                v_cnt <= v_cnt + VW'(1);
            end
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_mode      <= '0;
            cfg_level     <= '0;
            cfg_defect_en <= 1'b0;
            cfg_step      <= '0;
            lfsr          <= '0;
            dx            <= '0;
            dy            <= '0;
            hot           <= 1'b0;
        end else begin
            if (frame_start) begin
                cfg_mode      <= mode;
                cfg_level     <= level;
                cfg_defect_en <= defect_en;
                cfg_step      <= defect_step;
            end
            lfsr <= active ? lfsr_next : lfsr_cur;
            hot  <= inject ? ~hot_cur : hot_cur;
            if (active) begin
                dx <= (h_cnt == H_ACT_LAST) ? 8'd0 : dx_wrap;
            end else begin
                dx <= dx_cur;
            end
            dy <= act_line_end ? dy_wrap : dy_cur;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            out_href   <= 1'b0;
            out_vsync  <= 1'b0;
            out_raw    <= '0;
            out_defect <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_href   <= active;
            out_vsync  <= running && (v_cnt < V_SYNC);
            out_raw    <= active ? raw_next : '0;
            out_defect <= inject;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_isp_raw_stream_gen.sv
// Scoreboard bench for isp_raw_stream_gen: per-frame expected pixels are queued by the stimulus,
// and a negedge monitor compares timing, pixels and defect flags against them.
module tb_isp_raw_stream_gen;

    localparam int BITS  = 8;
    localparam int W     = 8;
    localparam int H     = 4;
    localparam int HB    = 4;
    localparam int VS    = 1;
    localparam int VBP   = 1;
    localparam int VFP   = 1;
    localparam int LINE  = W + HB;
    localparam int FRAME = LINE * (VS + VBP + H + VFP);
    localparam int NF    = 12;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  raw;
        logic        defect;
    } pix_t;

    logic            pclk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic [1:0]      mode;
    logic [BITS-1:0] level;
    logic            defect_en;
    logic [7:0]      defect_step;
    logic            out_href;
    logic            out_vsync;
    logic [BITS-1:0] out_raw;
    logic            out_defect;
    logic            frame_done;

    int unsigned cyc = 0;
    int          checks = 0;
    int          fails = 0;
    bit          mon_on = 1'b0;
    pix_t        exp_q[$];
    int unsigned frame_starts[$];

    int d_mode  [6] = '{1, 2, 0, 0, 3, 3};
    int d_level [6] = '{0, 'h80, 'h10, 'h10, 0, 0};
    int d_den   [6] = '{0, 0, 1, 1, 0, 0};
    int d_step  [6] = '{0, 0, 4, 3, 0, 0};

    isp_raw_stream_gen #(
        .BITS(BITS), .WIDTH(W), .HEIGHT(H), .HBLANK(HB),
        .VSYNC_LINES(VS), .VBP_LINES(VBP), .VFP_LINES(VFP), .BAYER(0)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .enable(enable), .mode(mode), .level(level),
        .defect_en(defect_en), .defect_step(defect_step),
        .out_href(out_href), .out_vsync(out_vsync), .out_raw(out_raw),
        .out_defect(out_defect), .frame_done(frame_done)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Reference model: pixels of one frame from the pattern rules, in raster order, stamped with output cycle.
    task automatic applyStimulus(input int m, input int lv, input int den, input int st, input int unsigned start);
        int unsigned lf;
        int unsigned fb;
        bit          hot;
        bit          inj;
        int          v;
        pix_t        p;
        mode        = m[1:0];
        level       = lv[7:0];
        defect_en   = den[0];
        defect_step = st[7:0];
        frame_starts.push_back(start);
        lf  = 32'hACE1;
        hot = 1'b1;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                case (m)
                    0: v = lv;
                    1: v = x % 256;
                    2: begin
                        if (y % 2 == 0) v = (x % 2 == 0) ? lv : lv / 2;
                        else            v = (x % 2 == 0) ? lv / 2 : lv / 4;
                    end
                    default: v = int'(lf >> 8);
                endcase
                fb = ((lf >> 15) ^ (lf >> 13) ^ (lf >> 12) ^ (lf >> 10)) & 1;
                lf = ((lf << 1) | fb) & 32'hFFFF;
                inj = 1'b0;
                if (den != 0 && st >= 4) begin
                    if (x % st == st - 1 && y % st == st - 1) inj = 1'b1;
                end
                if (inj) begin
                    v   = hot ? 255 : 0;
                    hot = !hot;
                end
                p.cyc    = start + (VS + VBP + y) * LINE + x;
                p.raw    = v[7:0];
                p.defect = inj;
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic waitCycle(input int unsigned target);
        while (cyc < target) @(negedge pclk);
        #1;
    endtask

    int unsigned off;
    int unsigned ln;
    logic        exp_vs;
    logic        exp_hr;
    logic        exp_fd;
    pix_t        got;

    always @(negedge pclk) begin
        if (mon_on) begin
            exp_vs = 1'b0;
            exp_hr = 1'b0;
            exp_fd = 1'b0;
            foreach (frame_starts[i]) begin
                if (cyc >= frame_starts[i] && cyc < frame_starts[i] + FRAME) begin
                    off    = cyc - frame_starts[i];
                    ln     = off / LINE;
                    exp_vs = (ln < VS);
                    exp_hr = (ln >= VS + VBP) && (ln < VS + VBP + H) && (off % LINE < W);
                    exp_fd = (off == FRAME - 1);
                end
            end
            checkOutput("vsync", out_vsync, exp_vs);
            checkOutput("href", out_href, exp_hr);
            checkOutput("frame_done", frame_done, exp_fd);
            if (out_href === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("pixel_pending", exp_q.size(), 1);
                end else begin
                    got = exp_q.pop_front();
                    checkOutput("pixel_cycle", cyc, got.cyc);
                    checkOutput("raw", out_raw, got.raw);
                    checkOutput("defect", out_defect, got.defect);
                end
            end else begin
                checkOutput("blank_raw", out_raw, 0);
                checkOutput("blank_defect", out_defect, 0);
            end
        end
    end

    int unsigned k;
    int unsigned start;

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        mode        = '0;
        level       = '0;
        defect_en   = 1'b0;
        defect_step = '0;
        repeat (3) @(negedge pclk);
        mon_on = 1'b1;
        #1;
        checkOutput("reset_href", out_href, 0);
        checkOutput("reset_vsync", out_vsync, 0);
        checkOutput("reset_raw", out_raw, 0);
        checkOutput("reset_frame_done", frame_done, 0);
        @(negedge pclk);
        #1 rst_n = 1'b1;
        waitCycle(cyc + 3);

        // Continuous frames; each next frame's settings are changed mid-frame of the current one.
        k      = cyc;
        start  = k + 2;
        enable = 1'b1;
        for (int f = 0; f < NF; f++) begin
            if (f < 6) begin
                applyStimulus(d_mode[f], d_level[f], d_den[f], d_step[f], start);
            end else begin
                applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                              int'($urandom_range(0, 1)),
                              ($urandom_range(0, 1) != 0) ? 4 : int'($urandom_range(0, 9)), start);
            end
            waitCycle(start + 40);
            start += FRAME;
        end
        enable = 1'b0;
        waitCycle(start + 30);

        // Reset in the middle of an active line, then an identical restart.
        k      = cyc;
        enable = 1'b1;
        applyStimulus(1, 0, 0, 0, k + 2);
        waitCycle(k + 2 + 30);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_href", out_href, 0);
        checkOutput("async_reset_vsync", out_vsync, 0);
        checkOutput("async_reset_raw", out_raw, 0);
        checkOutput("async_reset_defect", out_defect, 0);
        enable = 1'b0;
        exp_q.delete();
        frame_starts.delete();
        repeat (2) @(negedge pclk);
        #1 rst_n = 1'b1;
        waitCycle(cyc + 2);

        k      = cyc;
        enable = 1'b1;
        applyStimulus(1, 0, 0, 0, k + 2);
        waitCycle(k + 2 + 40);
        enable = 1'b0;
        waitCycle(k + 2 + FRAME + 20);

        checkOutput("pixels_left", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/isp_raw_stream_gen.md
Name: isp_raw_stream_gen

Overview:
- Source side of the raw pixel interface (pclk / href / vsync / raw) consumed by the ISP pipeline blocks, defect-pixel correction first among them.
- Generates frame timing and a Bayer raw test pattern, with optional injection of hot and dead pixels at a programmable pitch.
- Drives DPC benches and on-chip bring-up without a sensor.
- Exports a per-pixel defect flag aligned with the data so checkers can score correction.

Parameters:
- BITS, 8, raw pixel width (1..16)
- WIDTH, 1280, active pixels per line
- HEIGHT, 960, active lines per frame
- HBLANK, 160, blanking cycles per line (>=1)
- VSYNC_LINES, 2, line periods with vsync high
- VBP_LINES, 2, line periods between vsync fall and the first active line
- VFP_LINES, 2, line periods after the last active line
- BAYER, 0, 0:RGGB 1:GRBG 2:GBRG 3:BGGR

Ports:
- pclk  in  1  pixel clock
- rst_n  in  1  async active-low reset
- enable  in  1  run frames continuously while high
- mode  in  2  pattern: 0 flat, 1 ramp, 2 Bayer bars, 3 LFSR noise
- level  in  BITS  flat value; red value in bars mode
- defect_en  in  1  enable defect injection
- defect_step  in  8  defect pitch in x and y; <4 disables injection
- out_href  out  1  active pixel valid
- out_vsync  out  1  frame sync
- out_raw  out  BITS  pixel; 0 whenever out_href=0
- out_defect  out  1  current pixel is injected
- frame_done  out  1  one-cycle pulse at the end of each frame

Behaviour:
- Reset: async on rst_n=0. All outputs go to 0 immediately; state=IDLE; counters cleared.
- Line period L = WIDTH+HBLANK cycles. Frame = VSYNC_LINES+VBP_LINES+HEIGHT+VFP_LINES line periods.
- h_cnt runs 0..L-1. v_cnt advances when h_cnt wraps.
- FSM states: IDLE, FRAME.
  - IDLE -> FRAME on the edge where enable=1 is sampled. Counters are 0 at that point; outputs follow on the next edge.
  - FRAME -> FRAME (new frame) at the last cycle of the frame if enable=1; otherwise FRAME -> IDLE.
  - enable=0 mid-frame never truncates a frame.
- All outputs are registered, 1 cycle after the counter state:
  - out_vsync = (v_cnt < VSYNC_LINES).
  - out_href = (v_cnt in the active range) && (h_cnt < WIDTH).
- Configuration snapshot: mode, level, defect_en, defect_step are latched at every frame start (v_cnt=0, h_cnt=0). Changes mid-frame take effect next frame.
- Active coordinates: x = h_cnt, y = v_cnt-VSYNC_LINES-VBP_LINES.
- Patterns (all truncated to BITS):
  - mode 0: level.
  - mode 1: x mod 2^BITS.
  - mode 2: colour from BAYER and (y[0],x[0]): R=level, G=level>>1, B=level>>2.
  - mode 3: 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 at frame start, advances once per active pixel; output = lfsr[15:16-BITS].
- Injection:
  - dx counts 0..step-1 over active pixels and resets each line. dy counts 0..step-1 per active line and resets each frame.
  - Inject when defect_en && step>=4 && dx==step-1 && dy==step-1.
  - Injected value alternates hot (all ones) / dead (0), starting hot at each frame; the toggle advances per injected pixel.
  - out_defect=1 on that pixel only.
- frame_done is high on the same output cycle as the last frame cycle.
- LFSR and injection counters do not advance in blanking.

Test Plan (WIDTH=8, HEIGHT=4, HBLANK=4, VSYNC/VBP/VFP_LINES=1; L=12, frame=84 cycles):
- Reset, then enable=1 at cycle 0 -> out_vsync high on cycles 2..13. First out_href on cycle 26, high 8 cycles per line, 4 lines. frame_done pulse at cycle 85; the next vsync starts at cycle 86.
- mode=1 -> out_raw = 0,1,...,7 on every active line; out_raw=0 in blanking.
- mode=2, level=8'h80, BAYER=0 -> line 0 = 80,40,80,40...; line 1 = 40,20,40,20...
- mode=0, level=8'h10, defect_en=1, defect_step=4 -> (x3,y3)=FF, (x7,y3)=00, out_defect=1 only there. step=3 -> no injection.
- enable drop mid-frame -> frame completes and frame_done pulses, then outputs stay 0. rst_n=0 mid-line -> all outputs 0 that instant; restart is identical to the first scenario.
- mode=3 over two frames -> identical pixel sequences (LFSR reseeded); first active pixel = 8'hAC.
